mem_arbiter: RTL and testbench

//  Sequences and shares the byte-addressed, edge-strobed memory between two requesters:

---
 rtl/mem_ctrl_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 33 +++
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory arbiter: FSM state encodings and requester ids.
// Bit 0 of every two-bit grant/request vector is the fetch port, bit 1 the data port.
package mem_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_DATA) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational; the pointer moves to the
// port that lost only when the owner reports that the grant was taken.
module rr_arbiter2
    import mem_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic ptr_q;

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = port_onehot(ptr_q);
            default: grant_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= PORT_FETCH;
        end else if (accept_i && (grant_o != 2'b00)) begin
            ptr_q <= grant_o[0] ? PORT_DATA : PORT_FETCH;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares an edge-strobed memory between instruction fetch and the load/store unit,
// holding address/op/data a full cycle before the enable rises.
//
//   state     | meaning
//   ST_IDLE   | ready to the arbitration winner, request latched on accept
//   ST_SETUP  | mem select/address/data driven, enable low
//   ST_STROBE | enable high for one cycle, memory acts on its rising edge
//   ST_RESP   | one-cycle response pulse to the granted port
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int MEM_SIZE  = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 f_req_valid_i,
    output logic                 f_req_ready_o,
    input  logic [WORD_SIZE-1:0] f_req_addr_i,
    output logic                 f_resp_valid_o,
    output logic [WORD_SIZE-1:0] f_resp_rdata_o,
    output logic                 f_resp_err_o,
    input  logic                 d_req_valid_i,
    output logic                 d_req_ready_o,
    input  logic                 d_req_we_i,
    input  logic [WORD_SIZE-1:0] d_req_base_i,
    input  logic [WORD_SIZE-1:0] d_req_offset_i,
    input  logic [WORD_SIZE-1:0] d_req_wdata_i,
    output logic                 d_resp_valid_o,
    output logic [WORD_SIZE-1:0] d_resp_rdata_o,
    output logic                 d_resp_err_o,
    output logic                 mem_en_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic [WORD_SIZE-1:0] mem_addr_base_o,
    output logic [WORD_SIZE-1:0] mem_addr_offset_o,
    output logic [WORD_SIZE-1:0] mem_wdata_o,
    input  logic [WORD_SIZE-1:0] mem_rdata_i
);

    // Highest effective address at which a full word still fits in the memory.
    localparam logic [WORD_SIZE-1:0] EA_MAX = WORD_SIZE'(MEM_SIZE - 4);

    logic [1:0]           state_q;
    logic [1:0]           state_nxt;
    logic                 port_q;
    logic                 we_q;
    logic                 err_q;
    logic [1:0]           grant;
    logic                 idle;
    logic                 accept;
    logic                 win_port;
    logic                 win_we;
    logic                 win_err;
    logic [WORD_SIZE-1:0] win_base;
    logic [WORD_SIZE-1:0] win_offset;
    logic [WORD_SIZE-1:0] win_wdata;
    logic [WORD_SIZE-1:0] win_ea;
    logic                 port_nxt;
    logic                 we_nxt;
    logic                 err_nxt;
    logic                 access_nxt;
    logic                 resp_nxt;

    assign idle = (state_q == ST_IDLE);

    rr_arbiter2 u_rr_arbiter2 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    ({d_req_valid_i, f_req_valid_i}),
        .accept_i (accept),
        .grant_o  (grant)
    );

    assign f_req_ready_o = idle & grant[0];
    assign d_req_ready_o = idle & grant[1];
    assign accept        = idle & (|grant);
    assign win_port      = grant[1] ? PORT_DATA : PORT_FETCH;

    always_comb begin
        win_base   = f_req_addr_i;
        win_offset = '0;
        win_wdata  = '0;
        win_we     = 1'b0;
        if (win_port == PORT_DATA) begin
            win_base   = d_req_base_i;
            win_offset = d_req_offset_i;
            win_wdata  = d_req_wdata_i;
            win_we     = d_req_we_i;
        end
        // Effective address wraps modulo 2^WORD_SIZE before the bounds test.
        win_ea  = win_base + win_offset;
        win_err = (win_ea > EA_MAX);
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_nxt = win_err ? ST_RESP : ST_SETUP;
            ST_SETUP:  state_nxt = ST_STROBE;
            ST_STROBE: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        port_nxt   = accept ? win_port : port_q;
        we_nxt     = accept ? win_we   : we_q;
        err_nxt    = accept ? win_err  : err_q;
        access_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE);
        resp_nxt   = (state_nxt == ST_RESP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= ST_IDLE;
            port_q            <= PORT_FETCH;
            we_q              <= 1'b0;
            err_q             <= 1'b0;
            mem_addr_base_o   <= '0;
            mem_addr_offset_o <= '0;
            mem_wdata_o       <= '0;
        end else begin
            state_q <= state_nxt;
            port_q  <= port_nxt;
            we_q    <= we_nxt;
            err_q   <= err_nxt;
            if (accept) begin
                mem_addr_base_o   <= win_base;
                mem_addr_offset_o <= win_offset;
                mem_wdata_o       <= win_wdata;
            end
        end
    end

    // Memory controls are registered from the next state so the strobe is glitch-free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_en_o    <= 1'b0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
        end else begin
            mem_en_o    <= (state_nxt == ST_STROBE);
            mem_read_o  <= access_nxt & ~we_nxt;
            mem_write_o <= access_nxt &  we_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f_resp_valid_o <= 1'b0;
            d_resp_valid_o <= 1'b0;
            f_resp_err_o   <= 1'b0;
            d_resp_err_o   <= 1'b0;
        end else begin
            f_resp_valid_o <= resp_nxt & (port_nxt == PORT_FETCH);
            d_resp_valid_o <= resp_nxt & (port_nxt == PORT_DATA);
            f_resp_err_o   <= resp_nxt & (port_nxt == PORT_FETCH) & err_nxt;
            d_resp_err_o   <= resp_nxt & (port_nxt == PORT_DATA) & err_nxt;
        end
    end

    // Read data is captured on the STROBE->RESP edge so it is valid with the pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f_resp_rdata_o <= '0;
            d_resp_rdata_o <= '0;
        end else if ((state_q == ST_STROBE) && !we_q) begin
            if (port_q == PORT_FETCH) begin
                f_resp_rdata_o <= mem_rdata_i;
            end else begin
                d_resp_rdata_o <= mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level reference model checked every cycle,
// directed scenarios with hand-computed values, then randomized traffic with resets.
module tb_mem_arbiter;

    localparam int MSZ = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_valid, f_ready, f_resp_valid, f_resp_err;
    logic [31:0] f_addr, f_resp_rdata;
    logic        d_valid, d_ready, d_we, d_resp_valid, d_resp_err;
    logic [31:0] d_base, d_off, d_wdata, d_resp_rdata;
    logic        mem_en, mem_read, mem_write;
    logic [31:0] mem_base, mem_off, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clk = ~clk;

    mem_arbiter #(.WORD_SIZE(32), .MEM_SIZE(MSZ)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .f_req_valid_i     (f_valid),
        .f_req_ready_o     (f_ready),
        .f_req_addr_i      (f_addr),
        .f_resp_valid_o    (f_resp_valid),
        .f_resp_rdata_o    (f_resp_rdata),
        .f_resp_err_o      (f_resp_err),
        .d_req_valid_i     (d_valid),
        .d_req_ready_o     (d_ready),
        .d_req_we_i        (d_we),
        .d_req_base_i      (d_base),
        .d_req_offset_i    (d_off),
        .d_req_wdata_i     (d_wdata),
        .d_resp_valid_o    (d_resp_valid),
        .d_resp_rdata_o    (d_resp_rdata),
        .d_resp_err_o      (d_resp_err),
        .mem_en_o          (mem_en),
        .mem_read_o        (mem_read),
        .mem_write_o       (mem_write),
        .mem_addr_base_o   (mem_base),
        .mem_addr_offset_o (mem_off),
        .mem_wdata_o       (mem_wdata),
        .mem_rdata_i       (mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int en_count = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Environment memory: byte array, acts on the rising edge of the enable.
    logic [7:0]  env_mem [0:MSZ-1];
    logic [7:0]  ref_mem [0:MSZ-1];
    logic [31:0] env_ea;

    always @(posedge mem_en) begin
        en_count++;
        env_ea = mem_base + mem_off;
        if (env_ea <= 32'(MSZ - 4)) begin
            if (mem_write) begin
                env_mem[env_ea]     = mem_wdata[7:0];
                env_mem[env_ea + 1] = mem_wdata[15:8];
                env_mem[env_ea + 2] = mem_wdata[23:16];
                env_mem[env_ea + 3] = mem_wdata[31:24];
            end else if (mem_read) begin
                mem_rdata = {env_mem[env_ea + 3], env_mem[env_ea + 2],
                             env_mem[env_ea + 1], env_mem[env_ea]};
            end
        end
    end

    // Reference model: at most one transaction in flight, described by its accept cycle.
    logic        have_txn = 1'b0;
    logic        t_port, t_we, t_err;
    logic [31:0] t_base, t_off, t_wdata, t_rdata, t_ea;
    int          t_acc = 0;
    logic        ptr_m = 1'b0;
    logic [31:0] last_f = 32'h0, last_d = 32'h0;
    logic        exp_f_acc = 1'b0, exp_d_acc = 1'b0;
    int          m_d, m_lat;
    logic        e_en, e_sel, e_rd, e_wr, e_rsp;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            m_d   = cyc - t_acc;
            m_lat = t_err ? 1 : 3;
            e_en  = have_txn && !t_err && (m_d == 2);
            e_sel = have_txn && !t_err && (m_d == 1 || m_d == 2);
            e_rd  = e_sel && !t_we;
            e_wr  = e_sel && t_we;
            e_rsp = have_txn && (m_d == m_lat);
            if (e_en) begin
                t_ea = t_base + t_off;
                if (t_we) begin
                    ref_mem[t_ea]     = t_wdata[7:0];
                    ref_mem[t_ea + 1] = t_wdata[15:8];
                    ref_mem[t_ea + 2] = t_wdata[23:16];
                    ref_mem[t_ea + 3] = t_wdata[31:24];
                end else begin
                    t_rdata = {ref_mem[t_ea + 3], ref_mem[t_ea + 2],
                               ref_mem[t_ea + 1], ref_mem[t_ea]};
                end
            end
            if (e_rsp && !t_err && !t_we) begin
                if (t_port) last_d = t_rdata;
                else        last_f = t_rdata;
            end
            exp_f_acc = !have_txn && f_valid && (!d_valid || ptr_m == 1'b0);
            exp_d_acc = !have_txn && d_valid && (!f_valid || ptr_m == 1'b1);
            chk("f_ready", f_ready, exp_f_acc);
            chk("d_ready", d_ready, exp_d_acc);
            chk("mem_en", mem_en, e_en);
            chk("mem_read", mem_read, e_rd);
            chk("mem_write", mem_write, e_wr);
            chk("f_resp_valid", f_resp_valid, e_rsp && !t_port);
            chk("d_resp_valid", d_resp_valid, e_rsp && t_port);
            chk("f_resp_err", f_resp_err, e_rsp && !t_port && t_err);
            chk("d_resp_err", d_resp_err, e_rsp && t_port && t_err);
            chk("f_rdata", f_resp_rdata, last_f);
            chk("d_rdata", d_resp_rdata, last_d);
            if (e_sel) begin
                chk("mem_base", mem_base, t_base);
                chk("mem_offset", mem_off, t_off);
            end
            if (e_wr) chk("mem_wdata", mem_wdata, t_wdata);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            have_txn = 1'b0;
            ptr_m    = 1'b0;
            last_f   = 32'h0;
            last_d   = 32'h0;
        end else if (have_txn) begin
            if ((cyc - t_acc) >= (t_err ? 1 : 3)) have_txn = 1'b0;
        end else if (exp_f_acc || exp_d_acc) begin
            t_port   = exp_d_acc;
            t_we     = exp_d_acc && d_we;
            t_base   = exp_d_acc ? d_base : f_addr;
            t_off    = exp_d_acc ? d_off : 32'h0;
            t_wdata  = d_wdata;
            t_ea     = t_base + t_off;
            t_err    = (t_ea > 32'(MSZ - 4));
            t_acc    = cyc;
            have_txn = 1'b1;
            ptr_m    = ~t_port;
        end
        cyc++;
    end

    task automatic goto_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic req(input logic port, input logic we, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wd, output int n);
        @(posedge clk); #1;
        n = -1;
        if (port) begin
            d_valid = 1'b1; d_we = we; d_base = base; d_off = off; d_wdata = wd;
        end else begin
            f_valid = 1'b1; f_addr = base;
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ((port ? d_ready : f_ready) === 1'b1) begin
                n = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        f_valid = 1'b0;
        d_valid = 1'b0;
        chk("accept_seen", 32'(n >= 0), 32'd1);
    endtask

    int   n, en0, ng;
    int   g_cyc [0:7];
    logic g_port [0:7];

    initial begin
        for (int i = 0; i < MSZ; i++) begin
            env_mem[i] = 8'(i) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'hA5;
        end
        env_mem[4] = 8'h11; env_mem[5] = 8'h22; env_mem[6] = 8'h33; env_mem[7] = 8'h44;
        ref_mem[4] = 8'h11; ref_mem[5] = 8'h22; ref_mem[6] = 8'h33; ref_mem[7] = 8'h44;
        rst = 1'b1;
        f_valid = 1'b1; f_addr = 32'h0;
        d_valid = 1'b1; d_we = 1'b0; d_base = 32'h20; d_off = 32'h0; d_wdata = 32'h0;

        // Reset state with both requesters already asserting valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_base", mem_base, 0);
        chk("rst_mem_offset", mem_off, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_resp_valid", {f_resp_valid, d_resp_valid, f_resp_err, d_resp_err}, 0);
        chk("rst_rdata", f_resp_rdata | d_resp_rdata, 0);
        chk("rst_f_ready", f_ready, 1);
        chk("rst_d_ready", d_ready, 0);

        // Contention from reset: grants alternate F,D,F,D, four cycles apart.
        @(posedge clk); #1;
        rst = 1'b0;
        ng = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ng < 8 && f_ready === 1'b1) begin g_port[ng] = 1'b0; g_cyc[ng] = cyc; ng++; end
            if (ng < 8 && d_ready === 1'b1) begin g_port[ng] = 1'b1; g_cyc[ng] = cyc; ng++; end
        end
        chk("cont_grants", ng, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < ng) begin
                chk("cont_port", 32'(g_port[k]), 32'(k % 2));
                if (k > 0) chk("cont_gap", g_cyc[k] - g_cyc[k-1], 4);
            end
        end
        @(posedge clk); #1;
        f_valid = 1'b0; d_valid = 1'b0;

        // Store then load at ea 0x14.
        req(1'b1, 1'b1, 32'h10, 32'h4, 32'hDEADBEEF, n);
        goto_neg(n + 1);
        chk("st_setup_en", mem_en, 0);
        chk("st_setup_wr", mem_write, 1);
        goto_neg(n + 2);
        chk("st_strobe_en", mem_en, 1);
        goto_neg(n + 3);
        chk("st_resp_valid", d_resp_valid, 1);
        chk("st_resp_err", d_resp_err, 0);
        req(1'b1, 1'b0, 32'h10, 32'h4, 32'h0, n);
        goto_neg(n + 3);
        chk("ld_resp_valid", d_resp_valid, 1);
        chk("ld_rdata", d_resp_rdata, 32'hDEADBEEF);
        chk("ld_err", d_resp_err, 0);

        // Out-of-range load answers after one cycle and never strobes.
        en0 = en_count;
        req(1'b1, 1'b0, 32'(MSZ - 2), 32'h0, 32'h0, n);
        goto_neg(n + 1);
        chk("oor_resp_valid", d_resp_valid, 1);
        chk("oor_err", d_resp_err, 1);
        chk("oor_rdata_held", d_resp_rdata, 32'hDEADBEEF);
        goto_neg(n + 4);
        chk("oor_no_strobe", en_count - en0, 0);

        // Last legal word: bytes 0x3FC..0x3FF hold i^0xA5.
        req(1'b1, 1'b0, 32'(MSZ - 4), 32'h0, 32'h0, n);
        goto_neg(n + 3);
        chk("edge_err", d_resp_err, 0);
        chk("edge_rdata", d_resp_rdata, 32'h5A5B5859);

        // Address wrap: 0xFFFFFFFC + 8 = 4.
        req(1'b1, 1'b0, 32'hFFFFFFFC, 32'h8, 32'h0, n);
        goto_neg(n + 3);
        chk("wrap_err", d_resp_err, 0);
        chk("wrap_rdata", d_resp_rdata, 32'h44332211);

        req(1'b0, 1'b0, 32'h4, 32'h0, 32'h0, n);
        goto_neg(n + 3);
        chk("fetch_valid", f_resp_valid, 1);
        chk("fetch_rdata", f_resp_rdata, 32'h44332211);

        // Reset during the strobe of a store: write lands, no response, idle next cycle.
        req(1'b1, 1'b1, 32'h40, 32'h0, 32'hCAFEF00D, n);
        goto_neg(n + 2);
        chk("rs_strobe", mem_en, 1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        f_valid = 1'b1; f_addr = 32'h8;
        goto_neg(n + 3);
        chk("rs_no_resp", d_resp_valid, 0);
        chk("rs_en_low", mem_en, 0);
        chk("rs_idle_ready", f_ready, 1);
        chk("rs_word", {env_mem[67], env_mem[66], env_mem[65], env_mem[64]}, 32'hCAFEF00D);
        @(posedge clk); #1;
        f_valid = 1'b0;
        repeat (4) @(posedge clk);
        req(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, n);
        goto_neg(n + 3);
        chk("rs_readback", d_resp_rdata, 32'hCAFEF00D);

        // Randomized traffic, including drops of valid and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst     = ($urandom_range(0, 299) == 0);
            f_valid = ($urandom_range(0, 9) < 6);
            d_valid = ($urandom_range(0, 9) < 6);
            f_addr  = 32'($urandom_range(0, MSZ + 16));
            d_we    = $urandom_range(0, 1) == 1;
            d_wdata = $urandom;
            case ($urandom_range(0, 9))
                8: begin
                    d_base = 32'hFFFFFF00 + 32'($urandom_range(0, 255));
                    d_off  = 32'($urandom_range(0, 512));
                end
                9: begin
                    d_base = $urandom;
                    d_off  = $urandom;
                end
                default: begin
                    d_base = 32'($urandom_range(0, MSZ - 1));
                    d_off  = 32'($urandom_range(0, 16)) - 32'd8;
                end
            endcase
        end
        @(posedge clk); #1;
        rst = 1'b0; f_valid = 1'b0; d_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
